// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its result FIFO.
package rf_wb_arbiter_pkg;

    localparam int DATA_WID = 32;
    localparam int ADDR_WID = 5;

    localparam logic [ADDR_WID-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_WID-1:0] addr;
        logic [DATA_WID-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// Synchronous FIFO buffering MDU results until the regfile write port is free.
module wb_fifo #(
    parameter int DEPTH   = 2,
    parameter int WID     = 37,
    parameter int PTR_WID = $clog2(DEPTH),
    parameter int CNT_WID = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WID-1:0]     push_data,
    input  logic               pop,
    output logic [WID-1:0]     pop_data,
    output logic               full,
    output logic               empty,
    output logic [CNT_WID-1:0] count
);

    logic [WID-1:0]     mem [DEPTH];
    logic [PTR_WID-1:0] wr_ptr;
    logic [PTR_WID-1:0] rd_ptr;

    logic do_push;
    logic do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_WID'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: merges the MEM/WB result and buffered MDU results onto the
// single regfile write port and tracks registers awaiting an MDU result.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_WID   = rf_wb_arbiter_pkg::DATA_WID,
    parameter int ADDR_WID   = rf_wb_arbiter_pkg::ADDR_WID
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_valid,
    input  logic [ADDR_WID-1:0] pipe_addr,
    input  logic [DATA_WID-1:0] pipe_data,
    input  logic                mdu_issue,
    input  logic [ADDR_WID-1:0] mdu_issue_addr,
    input  logic                mdu_valid,
    input  logic [ADDR_WID-1:0] mdu_addr,
    input  logic [DATA_WID-1:0] mdu_data,
    output logic                mdu_ready,
    input  logic [ADDR_WID-1:0] rf_r1,
    input  logic [ADDR_WID-1:0] rf_r2,
    output logic                r1_busy,
    output logic                r2_busy,
    output logic                rf_we,
    output logic [ADDR_WID-1:0] rf_addr,
    output logic [DATA_WID-1:0] rf_din
);

    localparam int ENTRY_WID = $bits(wb_entry_t);
    localparam int CNT_WID   = $clog2(FIFO_DEPTH) + 1;
    localparam int NUM_REGS  = 2 ** ADDR_WID;

    wb_entry_t          push_entry;
    wb_entry_t          head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_WID-1:0] fifo_count;

    logic pipe_take;
    logic fifo_push;
    logic fifo_pop;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [6:0]          full_run;

    // Ready depends only on registered occupancy, so a pop never feeds back into ready.
    assign mdu_ready = !fifo_full && !rst;

    assign pipe_take = pipe_valid && (pipe_addr != REG_ZERO);
    // Results to x0 complete the handshake but are dropped here.
    assign fifo_push = mdu_valid && mdu_ready && (mdu_addr != REG_ZERO);
    assign fifo_pop  = !pipe_take && !fifo_empty;

    assign push_entry.addr = mdu_addr;
    assign push_entry.data = mdu_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WID   (ENTRY_WID)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_din  <= '0;
        end else if (pipe_take) begin
            rf_we   <= 1'b1;
            rf_addr <= pipe_addr;
            rf_din  <= pipe_data;
        end else if (fifo_pop) begin
            rf_we   <= 1'b1;
            rf_addr <= head_entry.addr;
            rf_din  <= head_entry.data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    // Clear on pop first, then set on issue, so a same-index set wins.
    always_comb begin
        busy_next = busy;
        if (fifo_pop) begin
            busy_next[head_entry.addr] = 1'b0;
        end
        if (mdu_issue && (mdu_issue_addr != REG_ZERO)) begin
            busy_next[mdu_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign r1_busy = (rf_r1 != REG_ZERO) && busy[rf_r1];
    assign r2_busy = (rf_r2 != REG_ZERO) && busy[rf_r2];

    // Consecutive cycles spent full; saturates so it never wraps back below the limit.
    always_ff @(posedge clk) begin
        if (rst || (fifo_count != CNT_WID'(FIFO_DEPTH))) begin
            full_run <= '0;
        end else if (full_run != 7'h7f) begin
            full_run <= full_run + 1'b1;
        end
    end

    a_no_starvation: assert property (@(posedge clk) disable iff (rst) full_run <= 7'd64)
        else $error("MDU result FIFO stayed full for more than 64 cycles");

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  rf_r1;
    logic [4:0]  rf_r2;
    logic        r1_busy;
    logic        r2_busy;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_din;

    int tests_run;
    int tests_failed;

    rf_wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_valid     (pipe_valid),
        .pipe_addr      (pipe_addr),
        .pipe_data      (pipe_data),
        .mdu_issue      (mdu_issue),
        .mdu_issue_addr (mdu_issue_addr),
        .mdu_valid      (mdu_valid),
        .mdu_addr       (mdu_addr),
        .mdu_data       (mdu_data),
        .mdu_ready      (mdu_ready),
        .rf_r1          (rf_r1),
        .rf_r2          (rf_r2),
        .r1_busy        (r1_busy),
        .r2_busy        (r2_busy),
        .rf_we          (rf_we),
        .rf_addr        (rf_addr),
        .rf_din         (rf_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past a rising edge; registered outputs are stable afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check({tag, ".we"}, 64'(rf_we), 64'(we));
        check({tag, ".addr"}, 64'(rf_addr), 64'(addr));
        check({tag, ".din"}, 64'(rf_din), 64'(data));
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        pipe_valid     = 1'b0;
        pipe_addr      = '0;
        pipe_data      = '0;
        mdu_issue      = 1'b0;
        mdu_issue_addr = '0;
        mdu_valid      = 1'b1;
        mdu_addr       = 5'd3;
        mdu_data       = 32'h7;
        rf_r1          = 5'd3;
        rf_r2          = 5'd4;

        // Reset held two cycles with an MDU result waiting.
        tick();
        tick();
        check_wr("reset", 1'b0, 5'd0, 32'h0);
        check("reset.ready", 64'(mdu_ready), 64'd0);
        check("reset.r1_busy", 64'(r1_busy), 64'd0);
        check("reset.r2_busy", 64'(r2_busy), 64'd0);
        rst       = 1'b0;
        mdu_valid = 1'b0;
        #1;
        check("release.ready", 64'(mdu_ready), 64'd1);

        // Pipe-only writes; x0 is treated as no write and the port holds.
        pipe_valid = 1'b1;
        pipe_addr  = 5'd8;
        pipe_data  = 32'h1234;
        tick();
        check_wr("pipe8", 1'b1, 5'd8, 32'h1234);
        pipe_addr = 5'd0;
        pipe_data = 32'h5555;
        tick();
        check_wr("pipe0", 1'b0, 5'd8, 32'h1234);
        pipe_valid = 1'b0;

        // MDU result held behind three cycles of pipe traffic.
        mdu_issue      = 1'b1;
        mdu_issue_addr = 5'd9;
        tick();
        mdu_issue = 1'b0;
        rf_r1     = 5'd9;
        rf_r2     = 5'd0;
        #1;
        check("issue9.r1_busy", 64'(r1_busy), 64'd1);
        check("issue9.r2_busy", 64'(r2_busy), 64'd0);
        pipe_valid = 1'b1;
        pipe_addr  = 5'd1;
        pipe_data  = 32'h100;
        mdu_valid  = 1'b1;
        mdu_addr   = 5'd9;
        mdu_data   = 32'hDEAD;
        #1;
        check("mdu9.ready", 64'(mdu_ready), 64'd1);
        tick();
        check_wr("behind.p1", 1'b1, 5'd1, 32'h100);
        mdu_valid = 1'b0;
        pipe_addr = 5'd2;
        pipe_data = 32'h200;
        tick();
        check_wr("behind.p2", 1'b1, 5'd2, 32'h200);
        check("behind.r1_busy", 64'(r1_busy), 64'd1);
        pipe_addr = 5'd3;
        pipe_data = 32'h300;
        tick();
        check_wr("behind.p3", 1'b1, 5'd3, 32'h300);
        pipe_valid = 1'b0;
        tick();
        check_wr("behind.mdu9", 1'b1, 5'd9, 32'hDEAD);
        check("behind.cleared", 64'(r1_busy), 64'd0);

        // Full backpressure under continuous pipe traffic, then ordered drain.
        rf_r1          = 5'd10;
        rf_r2          = 5'd11;
        mdu_issue      = 1'b1;
        mdu_issue_addr = 5'd10;
        tick();
        mdu_issue_addr = 5'd11;
        tick();
        mdu_issue  = 1'b0;
        pipe_valid = 1'b1;
        pipe_addr  = 5'd20;
        pipe_data  = 32'h1;
        mdu_valid  = 1'b1;
        mdu_addr   = 5'd10;
        mdu_data   = 32'hA10;
        tick();
        mdu_addr = 5'd11;
        mdu_data = 32'hA11;
        tick();
        mdu_addr = 5'd12;
        mdu_data = 32'hA12;
        #1;
        check("full.ready0", 64'(mdu_ready), 64'd0);
        tick();
        check_wr("full.pipe", 1'b1, 5'd20, 32'h1);
        check("full.ready1", 64'(mdu_ready), 64'd0);
        pipe_valid = 1'b0;
        #1;
        check("full.no_comb_ready", 64'(mdu_ready), 64'd0);
        tick();
        check_wr("drain.10", 1'b1, 5'd10, 32'hA10);
        check("drain.r1_busy", 64'(r1_busy), 64'd0);
        check("drain.ready", 64'(mdu_ready), 64'd1);
        tick();
        check_wr("drain.11", 1'b1, 5'd11, 32'hA11);
        check("drain.r2_busy", 64'(r2_busy), 64'd0);
        mdu_valid = 1'b0;
        tick();
        check_wr("drain.12", 1'b1, 5'd12, 32'hA12);
        tick();
        check("drain.idle", 64'(rf_we), 64'd0);

        // Same-cycle clear (pop of x5) and set (issue to x5): set wins.
        rf_r1          = 5'd5;
        mdu_valid      = 1'b1;
        mdu_addr       = 5'd5;
        mdu_data       = 32'h55;
        mdu_issue      = 1'b1;
        mdu_issue_addr = 5'd5;
        tick();
        mdu_valid  = 1'b0;
        pipe_valid = 1'b1;
        pipe_addr  = 5'd0;
        tick();
        check_wr("setclr.pop5", 1'b1, 5'd5, 32'h55);
        check("setclr.busy5", 64'(r1_busy), 64'd1);
        mdu_issue  = 1'b0;
        pipe_valid = 1'b0;

        // MDU result to x0 is accepted but never written.
        mdu_valid = 1'b1;
        mdu_addr  = 5'd0;
        mdu_data  = 32'h77;
        #1;
        check("x0.ready", 64'(mdu_ready), 64'd1);
        tick();
        mdu_valid = 1'b0;
        tick();
        check("x0.no_write", 64'(rf_we), 64'd0);

        // Reset with two queued entries and pending busy bits.
        rf_r1          = 5'd10;
        rf_r2          = 5'd11;
        mdu_issue      = 1'b1;
        mdu_issue_addr = 5'd10;
        tick();
        mdu_issue_addr = 5'd11;
        tick();
        mdu_issue  = 1'b0;
        pipe_valid = 1'b1;
        pipe_addr  = 5'd20;
        pipe_data  = 32'h2;
        mdu_valid  = 1'b1;
        mdu_addr   = 5'd10;
        mdu_data   = 32'hB10;
        tick();
        mdu_addr = 5'd11;
        mdu_data = 32'hB11;
        tick();
        mdu_valid = 1'b0;
        #1;
        check("midrst.pre_r1", 64'(r1_busy), 64'd1);
        check("midrst.pre_r2", 64'(r2_busy), 64'd1);
        check("midrst.pre_ready", 64'(mdu_ready), 64'd0);
        rst        = 1'b1;
        pipe_valid = 1'b0;
        tick();
        check("midrst.we", 64'(rf_we), 64'd0);
        check("midrst.r1", 64'(r1_busy), 64'd0);
        check("midrst.r2", 64'(r2_busy), 64'd0);
        rf_r1 = 5'd5;
        #1;
        check("midrst.busy5", 64'(r1_busy), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("midrst.quiet%0d", i), 64'(rf_we), 64'd0);
        end
        check("midrst.ready", 64'(mdu_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Writeback stage directly upstream of the register file. Owns the regfile write port (`rf_we`/`rf_addr`/`rf_din`).
- Merges two result sources onto that single port:
  - the in-order MEM/WB pipeline result, which is never stalled;
  - results from the multi-cycle multiply/divide unit (MDU), buffered in a small FIFO.
- Keeps a pending-write scoreboard so decode can detect reads of registers still awaiting an MDU result.

Parameters:
- `FIFO_DEPTH`, 2, number of buffered MDU results (power of two, ≥2)
- `DATA_WID`, 32, register data width
- `ADDR_WID`, 5, register address width

Ports:
- `clk`  in  1  system clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `pipe_valid`  in  1  MEM/WB has a register result this cycle
- `pipe_addr`  in  5  destination register of the pipeline result
- `pipe_data`  in  32  pipeline result data
- `mdu_issue`  in  1  decode issues an MDU op this cycle
- `mdu_issue_addr`  in  5  destination register of the issued MDU op
- `mdu_valid`  in  1  MDU result available
- `mdu_addr`  in  5  MDU result destination
- `mdu_data`  in  32  MDU result data
- `mdu_ready`  out  1  arbiter accepts the MDU result this cycle
- `rf_r1`  in  5  decode source register 1 (same value driven to the regfile)
- `rf_r2`  in  5  decode source register 2
- `r1_busy`  out  1  `rf_r1` has a pending MDU write
- `r2_busy`  out  1  `rf_r2` has a pending MDU write
- `rf_we`  out  1  regfile write enable (registered)
- `rf_addr`  out  5  regfile write address (registered)
- `rf_din`  out  32  regfile write data (registered)

Behaviour:
- **Reset:** `rf_we`=0, `rf_addr`=0, `rf_din`=0, FIFO empty (pointers 0, count 0), `busy[31:0]`=0. `mdu_ready`=0 while `rst`=1.
- **Write port register:** updated every posedge; the regfile commits it on the following negedge, giving 1-cycle latency from source to `rf_*`.
- **Arbitration priority:**
  - `pipe_valid`=1 and `pipe_addr`≠0: drive the pipe result; FIFO does not pop.
  - Otherwise, FIFO non-empty: pop the head onto the port.
  - Otherwise: `rf_we`=0, and `rf_addr`/`rf_din` hold their last values.
- **Register 0:**
  - A pipe result to register 0 is treated as absent, so the FIFO may use that slot.
  - An MDU result to register 0 is handshaken normally, then discarded (not enqueued).
- **MDU handshake:**
  - `mdu_ready` = !full && !rst, computed from registered count only.
  - A transfer occurs when `mdu_valid` && `mdu_ready`.
  - When full, `mdu_ready`=0 even if a pop happens in the same cycle; no combinational pop→ready path.
  - The MDU must hold `mdu_valid`/`mdu_addr`/`mdu_data` stable until accepted.
- **FIFO ordering:**
  - Strict FIFO order; pointers wrap modulo `FIFO_DEPTH`.
  - A simultaneous push and pop leaves count unchanged.
  - Pushing into an empty FIFO does not bypass the storage: the result reaches `rf_*` one cycle after it is enqueued at the earliest.
- **Scoreboard:**
  - `mdu_issue` && `mdu_issue_addr`≠0 sets `busy[mdu_issue_addr]` at posedge.
  - Popping an entry onto the write port clears `busy[entry.addr]` at that same posedge.
  - Set and clear of the same index in the same cycle: set wins.
  - Pipe writes never touch `busy`.
  - `r1_busy` = `busy[rf_r1]` and `r2_busy` = `busy[rf_r2]`, combinational; register 0 always reads 0.
- **Decode obligations (not checked by the arbiter):** decode stalls on a busy operand, and does not issue to a register that is already busy.
- **Reset mid-operation:** FIFO contents, `busy`, and any in-flight write are discarded. `rf_we` is 0 on the cycle after `rst` is sampled.
- **Starvation:** none by design, because the pipeline has bubbles. An assertion flags the FIFO staying full for more than 64 cycles.

Decomposition:
- Shared package holds:
  - `DATA_WID`/`ADDR_WID` constants;
  - `REG_ZERO`=5'd0;
  - a `wb_entry_t` struct {addr[4:0], data[31:0]}.
- Natural sub-module: `wb_fifo`, a synchronous FIFO with push/pop/full/empty and a count output, parameterised by depth and entry width.
- Arbitration and scoreboard stay in the top.

Test Plan:
- **Reset:** hold `rst` 2 cycles with `mdu_valid`=1. Expect `rf_we`=0, `mdu_ready`=0, `r1_busy`=`r2_busy`=0. Cycle after release: `mdu_ready`=1.
- **Pipe only:** `pipe_valid`=1, addr 8, data 0x1234 → next cycle `rf_we`=1, `rf_addr`=8, `rf_din`=0x1234. Then addr 0 → `rf_we`=0.
- **MDU behind pipe:**
  - Issue to reg 9 → `r1_busy`=1 with `rf_r1`=9.
  - MDU result (9, 0xDEAD) accepted while the pipe is valid for 3 cycles.
  - Expect the write of reg 9 on the first cycle the pipe is idle, and `busy[9]` cleared at that edge.
- **Full backpressure:**
  - Continuous pipe traffic; push MDU results to 10 and 11.
  - A third result sees `mdu_ready`=0 until a pop.
  - Drain order is 10, then 11.
- **Same-cycle set/clear:** pop an entry to reg 5 while `mdu_issue` targets 5 → `busy[5]` remains 1.
- **Reset mid-flight:** with 2 entries queued and `busy[10]`=`busy[11]`=1, assert `rst` → all busy clear, no further `rf_we` pulses.
